decode_operand: RTL and testbench
=================================

// Module: decode_operand
// PURPOSE
//  Decode/operand-fetch stage directly upstream of execute_alu. Accepts one 16-bit
//  instruction per cycle, reads the 8-bit register file and issues iOPCODE/iSOURCE0/
//  iSOURCE1-ready operands plus destination through a 1-entry output register.
//  Holds the architectural register file and a per-register busy scoreboard.
//  Stalls on RAW/WAW hazards until writeback clears them.
// PARAMETERS
//  REG_AW     3   register address width; register count = 2**REG_AW (fields below assume 3)
//  STALL_CW   16  width of the saturating hazard-stall cycle counter
// PORTS
//  iCLOCK        in   1        clock, all state on rising edge
//  iRESET        in   1        synchronous reset, active-high
//  iINST_VALID   in   1        upstream instruction valid
//  iINST         in   16       [15:12] opcode, [11] imm_sel, [10:8] rd, [7:0] imm / [2:0] rs
//  oINST_READY   out  1        instruction accepted this cycle when high with iINST_VALID
//  oVALID        out  1        issued operands valid
//  iREADY        in   1        execute stage consumes the issued operands
//  oOPCODE       out  4        opcode field, passed through unchanged
//  oSOURCE0      out  8        reg[rd]
//  oSOURCE1      out  8        imm_sel ? imm : reg[rs]
//  oDEST         out  REG_AW   rd, returned later on iWB_ADDR
//  iWB_VALID     in   1        writeback strobe
//  iWB_ADDR      in   REG_AW   writeback register
//  iWB_DATA      in   8        writeback data
//  oSTALL_COUNT  out  STALL_CW cycles with iINST_VALID=1 blocked by a hazard
// BEHAVIOUR
//  - Reset (sync, iRESET=1 at edge): oVALID=0, oOPCODE/oSOURCE0/oSOURCE1/oDEST=0.
//    All registers=0, scoreboard=0, oSTALL_COUNT=0. Reset overrides a simultaneous
//    accept or writeback; an in-flight issued op is dropped.
//  - hazard = busy[rd] | (~imm_sel & busy[rs]); each busy term is ignored when
//    iWB_VALID & iWB_ADDR matches that register and the bypass below is enabled.
//  - oINST_READY = ~hazard & (~oVALID | iREADY). This is combinational from iINST,
//    the scoreboard, and the iWB_* inputs.
//  - accept = iINST_VALID & oINST_READY. On accept, the output register loads at the next
//    edge and oVALID=1; latency is one cycle from accept to oVALID.
//  - oVALID & iREADY & ~accept -> oVALID=0 next cycle. oVALID & ~iREADY -> all outputs hold.
//  - Scoreboard: accept sets busy[rd]. iWB_VALID clears busy[iWB_ADDR]. If both target the
//    same register in the same cycle, set wins.
//  - Writeback to a non-busy register still writes the data.
//  - Register file: iWB_VALID writes reg[iWB_ADDR]<=iWB_DATA at the edge.
//  - oSTALL_COUNT increments when iINST_VALID & hazard & ~iRESET, and saturates at all-ones.
//  - Widths: data is 8 bit with no sign extension. rs uses iINST[2:0] and [7:3] are ignored.
//  - No register is hardwired; r0 is an ordinary register.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: a same-cycle writeback to a read register forwards iWB_DATA
//    into oSOURCE0/oSOURCE1 and removes that register's busy term from hazard. A
//    dependent instruction therefore issues in the same cycle as the writeback.
//  Not defined: reads see the pre-write register value and busy is evaluated before the
//    clear. A dependent instruction issues one cycle after the writeback.
// TESTING
//  - Reset then accept {op=1,imm_sel=1,rd=2,imm=8'h5A} with iREADY=1 -> next cycle
//    oVALID=1, oOPCODE=1, oSOURCE0=0, oSOURCE1=8'h5A, oDEST=2, busy[2]=1.
//  - WB r3<=8'h10. Then issue {op=2,imm_sel=0,rd=3,rs=3} -> oSOURCE0=oSOURCE1=8'h10.
//  - Issue rd=4, then immediately rd=5,rs=4 -> oINST_READY=0 and oSTALL_COUNT counts up.
//    Then WB r4=8'h33 -> with BYPASS_EN the op issues the same cycle with oSOURCE1=8'h33;
//    without it, the op issues one cycle later.
//  - Hold oVALID with iREADY=0 for 3 cycles -> outputs stable and oINST_READY=0. Then
//    iREADY=1 with a new valid instruction -> back-to-back issue with no bubble.
//  - Same-cycle accept rd=6 and WB addr 6 -> busy[6]=1 after the edge, and reg[6]=WB data.
//  - Assert iRESET with oVALID=1 and busy bits set -> next cycle oVALID=0, scoreboard=0,
//    oSTALL_COUNT=0. With STALL_CW=2, hold a hazard for 5 cycles -> count=3.

Source files
------------

// File: rtl/decode_operand.sv
// rtl/decode_operand.sv - decode/operand-fetch stage with register file, busy scoreboard and hazard stall; optional DECODE_WB_BYPASS_EN
module decode_operand #(
  parameter int REG_AW   = 3,
  parameter int STALL_CW = 16
) (
  input  logic                iCLOCK,
  input  logic                iRESET,
  input  logic                iINST_VALID,
  input  logic [15:0]         iINST,
  output logic                oINST_READY,
  output logic                oVALID,
  input  logic                iREADY,
  output logic [3:0]          oOPCODE,
  output logic [7:0]          oSOURCE0,
  output logic [7:0]          oSOURCE1,
  output logic [REG_AW-1:0]   oDEST,
  input  logic                iWB_VALID,
  input  logic [REG_AW-1:0]   iWB_ADDR,
  input  logic [7:0]          iWB_DATA,
  output logic [STALL_CW-1:0] oSTALL_COUNT
);
  localparam int NREG = 2**REG_AW;
  localparam logic [STALL_CW-1:0] STALL_ONE = STALL_CW'(1);

  logic [7:0]          r_regs [NREG];
  logic [NREG-1:0]     r_busy;
  logic                r_valid;
  logic [3:0]          r_opcode;
  logic [7:0]          r_src0;
  logic [7:0]          r_src1;
  logic [REG_AW-1:0]   r_dest;
  logic [STALL_CW-1:0] r_stall;

  logic [3:0]          w_op;
  logic                w_imm_sel;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs;
  logic [7:0]          w_imm;
  logic                w_busy_rd;
  logic                w_busy_rs;
  logic [7:0]          w_rd_data;
  logic [7:0]          w_rs_data;
  logic                w_hazard;
  logic                w_ready;
  logic                w_accept;

  assign w_op      = iINST[15:12];
  assign w_imm_sel = iINST[11];
  assign w_rd      = iINST[8 +: REG_AW];
  assign w_rs      = iINST[0 +: REG_AW];
  assign w_imm     = iINST[7:0];

`ifdef DECODE_WB_BYPASS_EN
  // A writeback landing this cycle both satisfies the dependency and supplies the data.
  logic w_wb_hit_rd;
  logic w_wb_hit_rs;
  assign w_wb_hit_rd = iWB_VALID & (iWB_ADDR == w_rd);
  assign w_wb_hit_rs = iWB_VALID & (iWB_ADDR == w_rs);
  assign w_busy_rd   = r_busy[w_rd] & ~w_wb_hit_rd;
  assign w_busy_rs   = r_busy[w_rs] & ~w_wb_hit_rs;
  assign w_rd_data   = w_wb_hit_rd ? iWB_DATA : r_regs[w_rd];
  assign w_rs_data   = w_wb_hit_rs ? iWB_DATA : r_regs[w_rs];
`else
  // Reads and busy checks see state as it was before this cycle's writeback.
  assign w_busy_rd   = r_busy[w_rd];
  assign w_busy_rs   = r_busy[w_rs];
  assign w_rd_data   = r_regs[w_rd];
  assign w_rs_data   = r_regs[w_rs];
`endif

  assign w_hazard    = w_busy_rd | (~w_imm_sel & w_busy_rs);
  assign w_ready     = ~w_hazard & (~r_valid | iREADY);
  assign w_accept    = iINST_VALID & w_ready;

  assign oINST_READY  = w_ready;
  assign oVALID       = r_valid;
  assign oOPCODE      = r_opcode;
  assign oSOURCE0     = r_src0;
  assign oSOURCE1     = r_src1;
  assign oDEST        = r_dest;
  assign oSTALL_COUNT = r_stall;

  // Register file: writeback always writes, whether or not the register is busy.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (iWB_VALID) begin
      r_regs[iWB_ADDR] <= iWB_DATA;
    end
  end

  // Scoreboard: writeback clears, accept sets; the later set wins on a same-register collision.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      r_busy <= '0;
    end else begin
      if (iWB_VALID) r_busy[iWB_ADDR] <= 1'b0;
      if (w_accept)  r_busy[w_rd]     <= 1'b1;
    end
  end

  // One-entry issue register: load on accept, drain when consumed, hold otherwise.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_src0   <= '0;
      r_src1   <= '0;
      r_dest   <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_opcode <= w_op;
      r_src0   <= w_rd_data;
      r_src1   <= w_imm_sel ? w_imm : w_rs_data;
      r_dest   <= w_rd;
    end else if (iREADY) begin
      r_valid  <= 1'b0;
    end
  end

  // Saturating count of cycles where a presented instruction is blocked by a hazard.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      r_stall <= '0;
    end else if (iINST_VALID && w_hazard && !(&r_stall)) begin
      r_stall <= r_stall + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_decode_operand.sv
// tb/tb_decode_operand.sv - self-checking bench for decode_operand with a behavioural scoreboard model
module tb_decode_operand;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, inst_valid, ready, wb_valid;
  logic [15:0] inst;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;

  logic        rdy, vld;
  logic [3:0]  op;
  logic [7:0]  s0, s1;
  logic [2:0]  dest;
  logic [15:0] stall;

  logic        b_rdy, b_vld;
  logic [3:0]  b_op;
  logic [7:0]  b_s0, b_s1;
  logic [2:0]  b_dest;
  logic [1:0]  b_stall;

  decode_operand #(.REG_AW(3), .STALL_CW(16)) u_dut (
    .iCLOCK(clk), .iRESET(rst), .iINST_VALID(inst_valid), .iINST(inst),
    .oINST_READY(rdy), .oVALID(vld), .iREADY(ready), .oOPCODE(op),
    .oSOURCE0(s0), .oSOURCE1(s1), .oDEST(dest), .iWB_VALID(wb_valid),
    .iWB_ADDR(wb_addr), .iWB_DATA(wb_data), .oSTALL_COUNT(stall)
  );

  decode_operand #(.REG_AW(3), .STALL_CW(2)) u_dut_sat (
    .iCLOCK(clk), .iRESET(rst), .iINST_VALID(inst_valid), .iINST(inst),
    .oINST_READY(b_rdy), .oVALID(b_vld), .iREADY(ready), .oOPCODE(b_op),
    .oSOURCE0(b_s0), .oSOURCE1(b_s1), .oDEST(b_dest), .iWB_VALID(wb_valid),
    .iWB_ADDR(wb_addr), .iWB_DATA(wb_data), .oSTALL_COUNT(b_stall)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural registers, busy flags and the issued operand slot.
  int m_reg  [8];
  bit m_busy [8];
  bit m_valid;
  int m_op, m_s0, m_s1, m_dest;
  int m_stall;
  bit started = 1'b0;

  function automatic bit wb_hits(input int r);
    return wb_valid && (int'(wb_addr) == r);
  endfunction

  function automatic bit blocked(input int r);
    return m_busy[r] && !(BYP && wb_hits(r));
  endfunction

  function automatic bit m_hazard();
    return blocked(int'(inst[10:8])) || (!inst[11] && blocked(int'(inst[2:0])));
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && (!m_valid || ready);
  endfunction

  function automatic int m_read(input int r);
    return (BYP && wb_hits(r)) ? int'(wb_data) : m_reg[r];
  endfunction

  always @(posedge clk) begin
    bit acc, hz;
    hz  = m_hazard();
    acc = inst_valid && m_ready();
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_busy[i] = 1'b0; end
      m_valid = 1'b0; m_op = 0; m_s0 = 0; m_s1 = 0; m_dest = 0; m_stall = 0;
      started = 1'b1;
    end else begin
      if (acc) begin
        m_op    = int'(inst[15:12]);
        m_s0    = m_read(int'(inst[10:8]));
        m_s1    = inst[11] ? int'(inst[7:0]) : m_read(int'(inst[2:0]));
        m_dest  = int'(inst[10:8]);
        m_valid = 1'b1;
      end else if (ready) begin
        m_valid = 1'b0;
      end
      if (inst_valid && hz) m_stall++;
      if (wb_valid) begin
        m_reg[wb_addr]  = int'(wb_data);
        m_busy[wb_addr] = 1'b0;
      end
      if (acc) m_busy[inst[10:8]] = 1'b1;
    end
  end

  // Compare both instances against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (started) begin
      check("ready", rdy, m_ready());
      check("valid", vld, m_valid);
      check("stall", stall, (m_stall > 65535) ? 65535 : m_stall);
      check("sat_ready", b_rdy, m_ready());
      check("sat_valid", b_vld, m_valid);
      check("sat_stall", b_stall, (m_stall > 3) ? 3 : m_stall);
      if (m_valid) begin
        check("opcode", op, m_op);
        check("src0", s0, m_s0);
        check("src1", s1, m_s1);
        check("dest", dest, m_dest);
        check("sat_src", {b_op, b_s0, b_s1, 1'b0, b_dest}, {m_op[3:0], m_s0[7:0], m_s1[7:0], 1'b0, m_dest[2:0]});
      end
    end
  end

  task automatic set_in(input bit v, input logic [15:0] i, input bit r,
                        input bit wv, input logic [2:0] wa, input logic [7:0] wd);
    rst = 1'b0; inst_valid = v; inst = i; ready = r;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = '0; ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    check("rst_valid", vld, 0);
    check("rst_outs", {op, s0, s1, 1'b0, dest}, 0);
    check("rst_stall", stall, 0);

    // Immediate issue into r2.
    set_in(1'b1, 16'h1A5A, 1'b1, 1'b0, 3'd0, 8'h00); tick();
    check("imm_valid", vld, 1);
    check("imm_op", op, 1);
    check("imm_src0", s0, 8'h00);
    check("imm_src1", s1, 8'h5A);
    check("imm_dest", dest, 2);
    set_in(1'b0, 16'h1A00, 1'b1, 1'b0, 3'd0, 8'h00); #1;
    check("busy2_blocks", rdy, 0);
    tick();

    // Writeback r3 then read it as both operands.
    set_in(1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 8'h10); tick();
    set_in(1'b1, 16'h2303, 1'b1, 1'b0, 3'd0, 8'h00); tick();
    check("rr_op", op, 2);
    check("rr_src0", s0, 8'h10);
    check("rr_src1", s1, 8'h10);

    // RAW on r4: stall for three cycles, then release with a writeback.
    set_in(1'b1, 16'h3C00, 1'b1, 1'b0, 3'd0, 8'h00); tick();
    set_in(1'b1, 16'h4504, 1'b1, 1'b0, 3'd0, 8'h00); #1;
    check("raw_ready", rdy, 0);
    tick(); tick(); tick();
    check("raw_stall3", stall, 3);
    set_in(1'b1, 16'h4504, 1'b1, 1'b1, 3'd4, 8'h33); #1;
    check("wb_cycle_ready", rdy, BYP ? 1 : 0);
    tick();
    if (!BYP) begin
      check("nobyp_stall4", stall, 4);
      set_in(1'b1, 16'h4504, 1'b1, 1'b0, 3'd0, 8'h00); #1;
      check("nobyp_ready", rdy, 1);
      tick();
    end else begin
      check("byp_stall3", stall, 3);
    end
    check("raw_src1", s1, 8'h33);
    check("raw_dest", dest, 5);

    // Back-pressure: hold for three cycles, then back-to-back issue.
    set_in(1'b1, 16'h5F77, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", rdy, 0);
      tick();
      check("hold_outs", {vld, op, s1, 1'b0, dest}, {1'b1, 4'd4, 8'h33, 1'b0, 3'd5});
    end
    set_in(1'b1, 16'h5F77, 1'b1, 1'b0, 3'd0, 8'h00); tick();
    check("b2b1", {vld, op, s1, 1'b0, dest}, {1'b1, 4'd5, 8'h77, 1'b0, 3'd7});
    set_in(1'b1, 16'h6911, 1'b1, 1'b0, 3'd0, 8'h00); #1;
    check("b2b_ready", rdy, 1);
    tick();
    check("b2b2", {vld, op, s1, 1'b0, dest}, {1'b1, 4'd6, 8'h11, 1'b0, 3'd1});

    // Same-cycle accept and writeback to r6: busy must remain set.
    set_in(1'b1, 16'h7E01, 1'b1, 1'b1, 3'd6, 8'hC3); tick();
    check("same_dest", dest, 6);
    set_in(1'b0, 16'h0600, 1'b1, 1'b0, 3'd0, 8'h00); #1;
    check("same_busy6", rdy, 0);

    // Reset with an op in flight and busy bits set.
    rst = 1'b1; tick();
    check("rst2_valid", vld, 0);
    check("rst2_stall", stall, 0);
    set_in(1'b0, 16'h0600, 1'b1, 1'b0, 3'd0, 8'h00); #1;
    check("rst2_sb_clear", rdy, 1);

    // Saturation: five hazard cycles against a 2-bit counter.
    set_in(1'b1, 16'h0A00, 1'b1, 1'b0, 3'd0, 8'h00); tick();
    set_in(1'b1, 16'h0302, 1'b1, 1'b0, 3'd0, 8'h00);
    repeat (5) tick();
    check("stall5", stall, 5);
    check("sat_stall3", b_stall, 3);

    // Randomised traffic against the model.
    repeat (3000) begin
      rst        = ($urandom_range(0, 99) == 0);
      inst_valid = ($urandom_range(0, 9) < 7);
      inst       = 16'($urandom);
      ready      = ($urandom_range(0, 9) < 7);
      wb_valid   = ($urandom_range(0, 9) < 3);
      wb_addr    = 3'($urandom);
      wb_data    = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
